// File: rtl/slave_responder_if.sv
// -----------------------------------------------------------------------------
// slave_responder_if
// Single-channel request/acknowledge bus between a bus master and a
// memory-backed responder.
//
// Signals:
//   req    master -> slave  request, qualifies cmd/addr/wdata
//   cmd    master -> slave  1 = write, 0 = read
//   addr   master -> slave  32-bit word address
//   wdata  master -> slave  32-bit write data (ignored on reads)
//   ack    slave -> master  one-cycle completion pulse
//   rdata  slave -> master  read data, valid with ack, held afterwards
//   busy   slave -> master  high from capture through the ack cycle
//   err    slave -> master  address error, valid with ack
//
// Modports: master (drives the request side), slave (drives the response side).
// -----------------------------------------------------------------------------
interface slave_responder_if;
    logic        req;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    modport master (
        output req, cmd, addr, wdata,
        input  ack, rdata, busy, err
    );

    modport slave (
        input  req, cmd, addr, wdata,
        output ack, rdata, busy, err
    );
endinterface

// File: rtl/slave_responder.sv
// -----------------------------------------------------------------------------
// slave_responder
// Memory-backed bus responder. Captures one transaction per request, waits
// LATENCY cycles, then commits a write or returns read data together with a
// one-cycle ack pulse. With LATENCY = 0 the capture edge goes straight to the
// ack cycle.
//
// Parameters:
//   MEM_DEPTH  number of 32-bit words (power of two, 2..256)
//   LATENCY    wait-state cycles between capture and ack (0..15)
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   slave_responder_if.slave (req/cmd/addr/wdata in, ack/rdata/busy/err out)
//
// Optional feature (compile-time macro SLAVE_RANGE_CHECK_EN):
//   defined   : addresses >= MEM_DEPTH complete normally but raise err in the
//               ack cycle; writes are dropped and reads return 0.
//   undefined : the address is truncated to the index width and err is tied 0.
// -----------------------------------------------------------------------------
module slave_responder #(
    parameter int MEM_DEPTH = 16,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    slave_responder_if.slave  bus
);

    localparam int         IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] LAT   = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]       state;
    logic [3:0]       cnt;

    // Transaction latched at capture; immune to the master changing the bus.
    logic             cmd_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
`ifdef SLAVE_RANGE_CHECK_EN
    logic             oor_q;
`endif

    logic [31:0]      mem [MEM_DEPTH];
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             capture;
    logic             enter_ack;
    logic             eff_cmd;
    logic [IDX_W-1:0] eff_idx;
    logic [31:0]      eff_wdata;
    logic             eff_oor;

    // With LATENCY = 0 the commit happens on the capture edge itself, so the
    // transaction fields must come straight from the bus in that case.
    always_comb begin
        capture   = (state == S_IDLE) && bus.req;
        enter_ack = (capture && (LATENCY == 0)) ||
                    ((state == S_WAIT) && (cnt == 4'd1));
        eff_cmd   = cmd_q;
        eff_idx   = idx_q;
        eff_wdata = wdata_q;
        eff_oor   = 1'b0;
        if (state == S_IDLE) begin
            eff_cmd   = bus.cmd;
            eff_idx   = bus.addr[IDX_W-1:0];
            eff_wdata = bus.wdata;
`ifdef SLAVE_RANGE_CHECK_EN
            eff_oor   = (bus.addr[31:IDX_W] != '0);
`endif
        end else begin
`ifdef SLAVE_RANGE_CHECK_EN
            eff_oor   = oor_q;
`endif
        end
    end

    // ---- capture stage: latch request fields ----
    always_ff @(posedge clk) begin
        if (capture) begin
            cmd_q   <= bus.cmd;
            idx_q   <= bus.addr[IDX_W-1:0];
            wdata_q <= bus.wdata;
`ifdef SLAVE_RANGE_CHECK_EN
            oor_q   <= (bus.addr[31:IDX_W] != '0);
`endif
        end
    end

    // ---- control: IDLE -> WAIT (cnt = LATENCY) -> ACK -> IDLE ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        if (LATENCY == 0) begin
                            state <= S_ACK;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= LAT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ---- commit stage: memory write on the edge entering ACK ----
    // Reset clears every word, so a write pending at reset is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (enter_ack && eff_cmd && !eff_oor) begin
            mem[eff_idx] <= eff_wdata;
        end
    end

    // ---- response stage: read data and error flag ----
    // err is only ever high in the ack cycle; rdata only changes on reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (enter_ack) begin
                err_q <= eff_oor;
                if (!eff_cmd) begin
                    rdata_q <= eff_oor ? 32'h0 : mem[eff_idx];
                end
            end
        end
    end

    assign bus.ack   = (state == S_ACK);
    assign bus.busy  = (state != S_IDLE);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

endmodule
